// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared funct3 codes, FSM state encoding and request legality check for the LSU
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef logic [2:0] lsu_state_t;

  localparam lsu_state_t ST_IDLE  = 3'd0;
  localparam lsu_state_t ST_RD    = 3'd1;
  localparam lsu_state_t ST_WR    = 3'd2;
  localparam lsu_state_t ST_MERGE = 3'd3;
  localparam lsu_state_t ST_LDATA = 3'd4;
  localparam lsu_state_t ST_RESP  = 3'd5;

  // 1 when the request must be answered with rsp_err and no memory access
  function automatic logic lsu_req_err(input logic       we,
                                       input logic [2:0] f3,
                                       input logic [1:0] addr_lo);
    logic illegal;
    logic misaligned;
    if (we) begin
      illegal = !(f3 inside {F3_B, F3_H, F3_W});
    end else begin
      illegal = !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    end
    misaligned = ((f3 == F3_H || f3 == F3_HU) && addr_lo[0]) ||
                 ((f3 == F3_W) && (addr_lo != 2'b00));
    return illegal || misaligned;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - combinational little-endian load extract and sub-word store merge
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] load_data,
  output logic [31:0] store_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    load_data = rdata;
    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data = {24'h000000, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data = {16'h0000, half_sel};
      default: load_data = rdata;
    endcase
  end

  // Memory has no byte enables, so sub-word stores rewrite the whole word
  always_comb begin
    store_data = rdata;
    case (funct3)
      F3_B: store_data[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      F3_H: begin
        if (addr_lo[1]) begin
          store_data[31:16] = wdata[15:0];
        end else begin
          store_data[15:0] = wdata[15:0];
        end
      end
      default: store_data = wdata;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - RV32I load/store unit driving a word-wide registered-read data memory
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_rd,
  output logic              rsp_valid,
  output logic [31:0]       rsp_data,
  output logic [4:0]        rsp_rd,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  lsu_state_t        state;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [4:0]        rd_q;
  logic              err_q;
  logic [31:0]       load_q;

  logic              req_err;
  logic [31:0]       align_load;
  logic [31:0]       align_store;

  // Address bits above the memory depth wrap silently
  logic              unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

  assign req_err = lsu_req_err(req_we, req_funct3, req_addr[1:0]);

  lsu_align u_align (
    .rdata      (mem_rdata),
    .wdata      (wdata_q),
    .addr_lo    (addr_q[1:0]),
    .funct3     (f3_q),
    .load_data  (align_load),
    .store_data (align_store)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      rd_q    <= 5'd0;
      err_q   <= 1'b0;
      load_q  <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            addr_q  <= req_addr[ADDR_W+1:0];
            wdata_q <= req_wdata;
            rd_q    <= req_rd;
            err_q   <= req_err;
            if (req_err) begin
              state <= ST_RESP;
            end else if (req_we && req_funct3 == F3_W) begin
              state <= ST_WR;
            end else begin
              state <= ST_RD;
            end
          end
        end
        ST_RD:    state <= we_q ? ST_MERGE : ST_LDATA;
        ST_LDATA: begin
          load_q <= align_load;
          state  <= ST_RESP;
        end
        ST_MERGE: state <= ST_RESP;
        ST_WR:    state <= ST_RESP;
        ST_RESP:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Strobes are masked by rst so a reset in MERGE cannot land a partial write
  assign req_ready = (state == ST_IDLE);
  assign mem_ren   = (state == ST_RD) && !rst;
  assign mem_wen   = ((state == ST_WR) || (state == ST_MERGE)) && !rst;
  assign rsp_valid = (state == ST_RESP) && !rst;
  assign mem_addr  = addr_q[ADDR_W+1:2];

  always_comb begin
    mem_wdata = 32'd0;
    if (state == ST_WR) begin
      mem_wdata = wdata_q;
    end else if (state == ST_MERGE) begin
      mem_wdata = align_store;
    end
  end

  always_comb begin
    rsp_data = 32'd0;
    rsp_rd   = 5'd0;
    rsp_err  = 1'b0;
    if (state == ST_RESP) begin
      rsp_err = err_q;
      if (!err_q && !we_q) begin
        rsp_data = load_q;
        rsp_rd   = rd_q;
      end
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - scoreboard bench for lsu_ctrl with a registered-read memory model
module tb_lsu_ctrl;

  localparam int ADDR_W = 5;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic [4:0]        req_rd;
  logic              rsp_valid;
  logic [31:0]       rsp_data;
  logic [4:0]        rsp_rd;
  logic              rsp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ren;
  logic              mem_wen;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem[DEPTH];
  logic [31:0] ref_mem[DEPTH];
  logic        mem_init;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  lsu_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_rd     (req_rd),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_rd     (rsp_rd),
    .rsp_err    (rsp_err),
    .mem_addr   (mem_addr),
    .mem_ren    (mem_ren),
    .mem_wen    (mem_wen),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  function automatic logic [31:0] init_word(input int i);
    if (i == 2) return 32'h11223344;
    if (i == 3) return 32'h8899AABB;
    return 32'h01010101 * i ^ 32'hA5C3_0F96;
  endfunction

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= init_word(i);
    end else begin
      if (mem_ren) mem_rdata <= mem[mem_addr];
      if (mem_wen) mem[mem_addr] <= mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [1:0] a);
    logic [31:0] sh;
    sh = w >> (8 * a);
    case (f3)
      3'd0:    return {{24{sh[7]}}, sh[7:0]};
      3'd4:    return {24'd0, sh[7:0]};
      3'd1:    return {{16{sh[15]}}, sh[15:0]};
      3'd5:    return {16'd0, sh[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [31:0] d,
                                            input logic [2:0] f3, input logic [1:0] a);
    logic [31:0] m;
    case (f3)
      3'd0:    m = 32'h000000FF << (8 * a);
      3'd1:    m = 32'h0000FFFF << (8 * a);
      default: m = 32'hFFFFFFFF;
    endcase
    return (w & ~m) | ((d << (8 * a)) & m);
  endfunction

  always @(negedge clk) begin
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", {31'd0, rsp_valid}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rsp_data", rsp_data, e.data);
        check("rsp_rd", {27'd0, rsp_rd}, {27'd0, e.rd});
        check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
      end
    end
  end

  // Called just after a negedge with the DUT idle; returns just after a negedge, idle again
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] rd,
                       input logic [31:0] exp_data, input logic [4:0] exp_rd,
                       input logic exp_err, input int exp_ren, input int exp_wen,
                       input logic [31:0] exp_wdata, input int exp_lat);
    int ren_at = 0, wen_at = 0, rsp_at = 0, rsp_n = 0, both = 0;
    logic [31:0] wd_seen = 32'd0;
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_rd = rd;
    req_valid = 1'b1;
    check("ready_idle", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    exp_q.push_back('{data: exp_data, rd: exp_rd, err: exp_err});
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (mem_ren && ren_at == 0) ren_at = k;
      if (mem_wen && wen_at == 0) begin
        wen_at = k;
        wd_seen = mem_wdata;
      end
      if (mem_ren && mem_wen) both++;
      if (rsp_valid) begin
        rsp_n++;
        if (rsp_at == 0) rsp_at = k;
      end
    end
    check("ren_cycle", ren_at, exp_ren);
    check("wen_cycle", wen_at, exp_wen);
    if (exp_wen != 0) begin
      check("mem_wdata", wd_seen, exp_wdata);
      ref_mem[addr[ADDR_W+1:2]] = exp_wdata;
    end
    check("rsp_cycle", rsp_at, exp_lat);
    check("rsp_pulses", rsp_n, 1);
    check("ren_wen_overlap", both, 0);
  endtask

  task automatic rand_op();
    logic        we;
    logic [2:0]  f3;
    logic [31:0] a, d, nw;
    logic [4:0]  rd;
    logic [2:0]  ld_ops[5];
    ld_ops = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    we = 1'($urandom_range(0, 1));
    f3 = we ? 3'($urandom_range(0, 2)) : ld_ops[$urandom_range(0, 4)];
    a  = $urandom();
    if (f3 == 3'd1 || f3 == 3'd5) a[0] = 1'b0;
    if (f3 == 3'd2) a[1:0] = 2'b00;
    d  = $urandom();
    rd = 5'($urandom_range(1, 31));
    if (we) begin
      nw = ref_store(ref_mem[a[ADDR_W+1:2]], d, f3, a[1:0]);
      if (f3 == 3'd2) issue(1'b1, f3, a, d, rd, 32'd0, 5'd0, 1'b0, 0, 1, nw, 2);
      else            issue(1'b1, f3, a, d, rd, 32'd0, 5'd0, 1'b0, 1, 2, nw, 3);
    end else begin
      issue(1'b0, f3, a, d, rd, ref_load(ref_mem[a[ADDR_W+1:2]], f3, a[1:0]), rd, 1'b0,
            1, 0, 32'd0, 3);
    end
  endtask

  initial begin
    int first_rsp, second_rsp;
    rst = 1'b1; mem_init = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; req_rd = 5'd0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
    repeat (3) @(posedge clk);
    #1 mem_init = 1'b0;
    @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_rsp_rd", {27'd0, rsp_rd}, 32'd0);
    check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("rst_mem_ren", {31'd0, mem_ren}, 32'd0);
    check("rst_mem_wen", {31'd0, mem_wen}, 32'd0);
    check("rst_mem_addr", {27'd0, mem_addr}, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);

    // Loads from word 3 = 0x8899AABB
    issue(1'b0, 3'd0, 32'h0F, 32'd0, 5'd5, 32'hFFFFFF88, 5'd5, 1'b0, 1, 0, 32'd0, 3);
    issue(1'b0, 3'd4, 32'h0F, 32'd0, 5'd6, 32'h00000088, 5'd6, 1'b0, 1, 0, 32'd0, 3);
    issue(1'b0, 3'd1, 32'h0C, 32'd0, 5'd7, 32'hFFFFAABB, 5'd7, 1'b0, 1, 0, 32'd0, 3);
    issue(1'b0, 3'd5, 32'h0E, 32'd0, 5'd8, 32'h00008899, 5'd8, 1'b0, 1, 0, 32'd0, 3);
    issue(1'b0, 3'd2, 32'h0C, 32'd0, 5'd9, 32'h8899AABB, 5'd9, 1'b0, 1, 0, 32'd0, 3);

    // Stores to word 2 = 0x11223344
    issue(1'b1, 3'd0, 32'h09, 32'hFFFFFF55, 5'd3, 32'd0, 5'd0, 1'b0, 1, 2, 32'h11225544, 3);
    issue(1'b1, 3'd2, 32'h08, 32'hDEADBEEF, 5'd3, 32'd0, 5'd0, 1'b0, 0, 1, 32'hDEADBEEF, 2);

    // Misaligned and illegal requests
    issue(1'b0, 3'd2, 32'h06, 32'd0, 5'd4, 32'd0, 5'd0, 1'b1, 0, 0, 32'd0, 1);
    issue(1'b1, 3'd1, 32'h03, 32'h1234, 5'd4, 32'd0, 5'd0, 1'b1, 0, 0, 32'd0, 1);
    issue(1'b0, 3'd3, 32'h0C, 32'd0, 5'd4, 32'd0, 5'd0, 1'b1, 0, 0, 32'd0, 1);
    issue(1'b1, 3'd4, 32'h08, 32'h1234, 5'd4, 32'd0, 5'd0, 1'b1, 0, 0, 32'd0, 1);

    // Back-to-back with req_valid held; second request presented while busy
    req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h0C; req_wdata = 32'd0; req_rd = 5'd1;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_funct3 = 3'd4; req_addr = 32'h0F; req_rd = 5'd2;
    exp_q.push_back('{data: 32'h8899AABB, rd: 5'd1, err: 1'b0});
    exp_q.push_back('{data: 32'h00000088, rd: 5'd2, err: 1'b0});
    first_rsp = 0; second_rsp = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k <= 3) check("b2b_busy_ready", {31'd0, req_ready}, 32'd0);
      if (k == 4) check("b2b_ready_after", {31'd0, req_ready}, 32'd1);
      if (rsp_valid) begin
        if (first_rsp == 0) first_rsp = k;
        else second_rsp = k;
      end
      if (k == 4) begin
        @(posedge clk);
        #1 req_valid = 1'b0;
      end
    end
    check("b2b_first_rsp", first_rsp, 3);
    check("b2b_second_rsp", second_rsp, 7);

    // Reset while an SH sits in MERGE
    req_we = 1'b1; req_funct3 = 3'd1; req_addr = 32'h0A; req_wdata = 32'h0000BEEF;
    req_rd = 5'd7; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("rmw_rd_ren", {31'd0, mem_ren}, 32'd1);
    @(negedge clk);
    check("rmw_merge_wen", {31'd0, mem_wen}, 32'd1);
    check("rmw_merge_wdata", mem_wdata, 32'hBEEFBEEF);
    rst = 1'b1;
    #1 check("rmw_rst_wen", {31'd0, mem_wen}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rmw_after_ready", {31'd0, req_ready}, 32'd1);
    check("rmw_after_rsp", {31'd0, rsp_valid}, 32'd0);
    check("rmw_after_wen", {31'd0, mem_wen}, 32'd0);
    check("rmw_mem_word", mem[2], 32'hDEADBEEF);
    issue(1'b0, 3'd2, 32'h08, 32'd0, 5'd10, 32'hDEADBEEF, 5'd10, 1'b0, 1, 0, 32'd0, 3);

    // Random legal traffic, upper address bits exercise wrap-around
    for (int n = 0; n < 40; n++) rand_op();

    repeat (3) @(negedge clk);
    check("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store unit between the execute stage and the word-addressed, registered-read data memory. Accepts one byte-addressed RV32I load or store per request and drives the memory's word-wide read/write port. Sub-word stores are performed as read-modify-write because the memory has no byte enables. Returns aligned, sign- or zero-extended load data tagged with the destination register.

## Interface
Parameters:
- ADDR_W, 5, word-index width of the data memory (DEPTH = 2**ADDR_W words)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  unit idle and able to accept
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
- req_addr  in  32  byte address (rs1 + imm)
- req_wdata  in  32  store data (rs2)
- req_rd  in  5  load destination register
- rsp_valid  out  1  one-cycle completion pulse
- rsp_data  out  32  extended load data; 0 for stores and errors
- rsp_rd  out  5  latched req_rd for loads; 0 for stores and errors
- rsp_err  out  1  misaligned address or illegal funct3
- mem_addr  out  ADDR_W  word index = latched addr[ADDR_W+1:2]
- mem_ren  out  1  memory read strobe; data returns the next cycle
- mem_wen  out  1  memory write strobe
- mem_wdata  out  32  write data
- mem_rdata  in  32  registered read data

## Operation
- FSM states: IDLE, RD, WR, MERGE, LDATA, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch we, funct3, addr, wdata, rd.
  - Next state: RESP with err if illegal or misaligned; WR for SW; RD otherwise.
- Legality:
  - Loads: funct3 must be in {0,1,2,4,5}. Stores: funct3 must be in {0,1,2}.
  - Misaligned: halfword with addr[0]=1, or word with addr[1:0]≠0.
  - An erroring request performs no memory access.
- RD:
  - mem_ren=1.
  - Next state: LDATA for loads, MERGE for SB/SH.
- LDATA:
  - Select the byte at addr[1:0] or the halfword at addr[1], little-endian.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - Register the result, then go to RESP.
- MERGE:
  - mem_wen=1.
  - mem_wdata = mem_rdata with the selected byte/halfword replaced by wdata[7:0] or wdata[15:0].
  - Then go to RESP.
- WR: mem_wen=1, mem_wdata=wdata, then go to RESP.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. The core has no backpressure on the response.
- req_valid outside IDLE is ignored (req_ready=0).
- Address bits above ADDR_W+1 are ignored, so the address wraps modulo DEPTH words.
- mem_ren and mem_wen are never asserted in the same cycle.

## Timing
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_data=0, rsp_rd=0, rsp_err=0, mem_ren=0, mem_wen=0, mem_addr=0, mem_wdata=0.
- Latency, with the accept edge at cycle T:
  - Load: RD at T+1, LDATA at T+2, rsp_valid at T+3.
  - SW: mem_wen at T+1, rsp_valid at T+2.
  - SB/SH: mem_ren at T+1, mem_wen at T+2, rsp_valid at T+3.
  - Error: rsp_valid with rsp_err=1 at T+1.
- Throughput: the next accept is possible in the cycle after RESP.
- rst mid-operation:
  - IDLE on the next edge; all strobes and rsp_valid are 0 from that edge.
  - A pending RMW is abandoned with no write.
- mem_addr stays stable from RD through MERGE.

## Structure
- Shared package `lsu_pkg`:
  - funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU.
  - FSM state enum.
  - Legality/misalignment function.
- One combinational sub-module `lsu_align`:
  - Load extract from (rdata, addr[1:0], funct3).
  - Store merge from (rdata, wdata, addr[1:0], funct3).
  - Unit-testable on its own.

## Test plan
- Preload word 3 = 0x8899AABB; LB addr 0x0F, rd=5 -> rsp_valid at T+3, rsp_data=0xFFFFFF88, rsp_rd=5; LBU same address -> 0x00000088.
- LH addr 0x0C -> 0xFFFFAABB; LHU addr 0x0E -> 0x00008899; LW addr 0x0C -> 0x8899AABB.
- Word 2 = 0x11223344; SB addr 0x09, wdata 0xFFFFFF55 -> mem_ren at T+1, mem_wen at T+2 with mem_wdata 0x11225544, rsp_valid at T+3 with rsp_data=0, rsp_rd=0; SW addr 0x08 data 0xDEADBEEF -> mem_wen at T+1, rsp_valid at T+2.
- Error cases -> rsp_valid at T+1 with rsp_err=1 and no mem_ren/mem_wen:
  - LW addr 0x06.
  - SH addr 0x03.
  - Load funct3=3.
  - Store funct3=4.
- Back-to-back requests with req_valid held high -> second accept only after RESP; the second request's fields are not latched while busy.
- rst asserted in MERGE of an SH -> no mem_wen, no rsp_valid, memory word unchanged, req_ready=1 the cycle after.
